wb_stage_pipe: RTL and testbench

//  Registered, parametrised writeback stage that sits between the MEM stage and
//  the register file. It provides the MEM/WB pipeline latch and a 3-way result

---
 rtl/wb_stage_pipe.sv | 106 ++++++++++
 tb/tb_wb_stage_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_pipe.sv
// MEM/WB pipeline latch: result select, sub-word load extraction, zero-register
// write suppression, stall/flush control and a retired-instruction counter.
module wb_stage_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int SUBWORD_EN = 1,
  parameter int ZERO_REG   = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [1:0]        src_sel,
  input  logic              reg_write_in,
  input  logic [1:0]        load_size,
  input  logic              load_unsigned,
  input  logic [1:0]        byte_off,
  input  logic [DATA_W-1:0] data_mem,
  input  logic [DATA_W-1:0] data_alu,
  input  logic [DATA_W-1:0] data_link,
  input  logic [REG_AW-1:0] regdst_in,
  output logic              wb_valid,
  output logic              reg_write,
  output logic [DATA_W-1:0] data_to_reg,
  output logic [REG_AW-1:0] regdst_out,
  output logic [CNT_W-1:0]  retired_cnt
);

  localparam logic [1:0] SRC_MEM  = 2'b01;
  localparam logic [1:0] SRC_LINK = 2'b10;
  localparam logic [1:0] SZ_BYTE  = 2'b01;
  localparam logic [1:0] SZ_HALF  = 2'b10;

  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] result;
  logic              zero_dst;
  logic              wr_next;
  logic              advance;
  logic              retire;

  // Lanes are little-endian; half loads ignore byte_off[0] since alignment is
  // enforced upstream. Reserved load_size 11 behaves as a word load.
  generate
    if (SUBWORD_EN != 0 && DATA_W >= 32) begin : g_subword
      logic [7:0]  byte_lane;
      logic [15:0] half_lane;
      always_comb begin
        case (byte_off)
          2'd0:    byte_lane = data_mem[7:0];
          2'd1:    byte_lane = data_mem[15:8];
          2'd2:    byte_lane = data_mem[23:16];
          default: byte_lane = data_mem[31:24];
        endcase
        half_lane = byte_off[1] ? data_mem[31:16] : data_mem[15:0];
        case (load_size)
          SZ_BYTE: load_data = {{(DATA_W-8){byte_lane[7] & ~load_unsigned}}, byte_lane};
          SZ_HALF: load_data = {{(DATA_W-16){half_lane[15] & ~load_unsigned}}, half_lane};
          default: load_data = data_mem;
        endcase
      end
    end else begin : g_word_only
      assign load_data = data_mem;
    end
  endgenerate

  always_comb begin
    case (src_sel)
      SRC_MEM:  result = load_data;
      SRC_LINK: result = data_link;
      default:  result = data_alu;
    endcase
  end

  assign zero_dst = (ZERO_REG != 0) && (regdst_in == '0);
  assign wr_next  = in_valid & reg_write_in & ~zero_dst;

  // Handshake: in_valid qualifies the MEM-stage fields; there is no ready.
  // stall holds the latch, flush invalidates it (flush wins over stall), and
  // a latched instruction retires whenever the latch moves on (flush or no stall).
  assign advance = flush | ~stall;
  assign retire  = wb_valid & advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid    <= 1'b0;
      reg_write   <= 1'b0;
      data_to_reg <= '0;
      regdst_out  <= '0;
      retired_cnt <= '0;
    end else begin
      if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
      if (flush) begin
        wb_valid  <= 1'b0;
        reg_write <= 1'b0;
      end else if (!stall) begin
        wb_valid    <= in_valid;
        reg_write   <= wr_next;
        data_to_reg <= result;
        regdst_out  <= regdst_in;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe: driver pushes expected latch contents into a
// queue, a monitor pops one entry per edge and compares all three DUT variants.
module tb_wb_stage_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, in_valid, reg_write_in, load_unsigned;
  logic [1:0]  src_sel, load_size, byte_off;
  logic [31:0] data_mem, data_alu, data_link;
  logic [4:0]  regdst_in;

  logic        wb_valid, reg_write;
  logic [31:0] data_to_reg;
  logic [4:0]  regdst_out;
  logic [15:0] retired_cnt;

  logic        z_wb_valid, z_reg_write;
  logic [31:0] z_data_to_reg;
  logic [4:0]  z_regdst_out;
  logic [15:0] z_retired_cnt;

  logic        c_wb_valid, c_reg_write;
  logic [31:0] c_data_to_reg;
  logic [4:0]  c_regdst_out;
  logic [3:0]  c_retired_cnt;

  wb_stage_pipe dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .src_sel(src_sel), .reg_write_in(reg_write_in), .load_size(load_size),
    .load_unsigned(load_unsigned), .byte_off(byte_off), .data_mem(data_mem),
    .data_alu(data_alu), .data_link(data_link), .regdst_in(regdst_in),
    .wb_valid(wb_valid), .reg_write(reg_write), .data_to_reg(data_to_reg),
    .regdst_out(regdst_out), .retired_cnt(retired_cnt)
  );

  wb_stage_pipe #(.ZERO_REG(0)) dut_z0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .src_sel(src_sel), .reg_write_in(reg_write_in), .load_size(load_size),
    .load_unsigned(load_unsigned), .byte_off(byte_off), .data_mem(data_mem),
    .data_alu(data_alu), .data_link(data_link), .regdst_in(regdst_in),
    .wb_valid(z_wb_valid), .reg_write(z_reg_write), .data_to_reg(z_data_to_reg),
    .regdst_out(z_regdst_out), .retired_cnt(z_retired_cnt)
  );

  wb_stage_pipe #(.CNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .src_sel(src_sel), .reg_write_in(reg_write_in), .load_size(load_size),
    .load_unsigned(load_unsigned), .byte_off(byte_off), .data_mem(data_mem),
    .data_alu(data_alu), .data_link(data_link), .regdst_in(regdst_in),
    .wb_valid(c_wb_valid), .reg_write(c_reg_write), .data_to_reg(c_data_to_reg),
    .regdst_out(c_regdst_out), .retired_cnt(c_retired_cnt)
  );

  typedef struct packed {
    logic        v;
    logic        we;
    logic        we_z;
    logic [31:0] d;
    logic [4:0]  rd;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Expected latch contents, advanced once per issued cycle.
  logic        m_v = 1'b0, m_we = 1'b0, m_wez = 1'b0;
  logic [31:0] m_d = '0;
  logic [4:0]  m_rd = '0;
  logic [15:0] m_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic vld, input logic [1:0] src, input logic we,
                        input logic [1:0] size, input logic uns, input logic [1:0] off,
                        input logic [31:0] mem, input logic [31:0] alu,
                        input logic [31:0] link, input logic [4:0] rd);
    in_valid = vld; src_sel = src; reg_write_in = we; load_size = size;
    load_unsigned = uns; byte_off = off; data_mem = mem; data_alu = alu;
    data_link = link; regdst_in = rd;
  endtask

  // exp_d is the hand-computed select/extract result for the current inputs.
  task automatic tick(input logic [31:0] exp_d);
    if (rst) begin
      m_v = 0; m_we = 0; m_wez = 0; m_d = '0; m_rd = '0; m_cnt = '0;
    end else begin
      if (m_v && (flush || !stall)) m_cnt = m_cnt + 16'd1;
      if (flush) begin
        m_v = 0; m_we = 0; m_wez = 0;
      end else if (!stall) begin
        m_v   = in_valid;
        m_wez = in_valid & reg_write_in;
        m_we  = m_wez & (regdst_in != 5'd0);
        m_d   = exp_d;
        m_rd  = regdst_in;
      end
    end
    exp_q.push_back('{v: m_v, we: m_we, we_z: m_wez, d: m_d, rd: m_rd, cnt: m_cnt});
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("wb_valid",      {31'd0, wb_valid},        {31'd0, mon_e.v});
      chk("reg_write",     {31'd0, reg_write},       {31'd0, mon_e.we});
      chk("data_to_reg",   data_to_reg,              mon_e.d);
      chk("regdst_out",    {27'd0, regdst_out},      {27'd0, mon_e.rd});
      chk("retired_cnt",   {16'd0, retired_cnt},     {16'd0, mon_e.cnt});
      chk("z0_reg_write",  {31'd0, z_reg_write},     {31'd0, mon_e.we_z});
      chk("c4_retired_cnt",{28'd0, c_retired_cnt},   {28'd0, mon_e.cnt[3:0]});
    end
  end

  initial begin
    rst = 1; stall = 0; flush = 0;
    set_in(0, 2'b00, 0, 2'b00, 0, 2'b00, '0, '0, '0, '0);

    // Reset with random inputs.
    for (int i = 0; i < 2; i++) begin
      stall = 1'($urandom_range(0, 1)); flush = 1'($urandom_range(0, 1));
      set_in(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
      tick(32'h0);
    end
    rst = 0; stall = 0; flush = 0;
    set_in(0, 2'b00, 0, 2'b00, 0, 2'b00, '0, '0, '0, '0);
    tick(32'h0);

    // Result select.
    set_in(1, 2'b00, 1, 2'b00, 0, 2'b00, 32'h0, 32'h11, 32'h44, 5'd5); tick(32'h11);
    src_sel = 2'b10; tick(32'h44);
    src_sel = 2'b11; tick(32'h11);

    // Sub-word loads from 0x80F17F02.
    set_in(1, 2'b01, 1, 2'b01, 0, 2'd3, 32'h80F17F02, 32'h11, 32'h44, 5'd6); tick(32'hFFFFFF80);
    set_in(1, 2'b01, 1, 2'b01, 1, 2'd3, 32'h80F17F02, 32'h11, 32'h44, 5'd6); tick(32'h00000080);
    set_in(1, 2'b01, 1, 2'b10, 0, 2'd2, 32'h80F17F02, 32'h11, 32'h44, 5'd6); tick(32'hFFFF80F1);
    set_in(1, 2'b01, 1, 2'b10, 1, 2'd0, 32'h80F17F02, 32'h11, 32'h44, 5'd6); tick(32'h00007F02);
    set_in(1, 2'b01, 1, 2'b00, 0, 2'd1, 32'h80F17F02, 32'h11, 32'h44, 5'd6); tick(32'h80F17F02);
    set_in(1, 2'b01, 1, 2'b01, 0, 2'd1, 32'h80F17F02, 32'h11, 32'h44, 5'd6); tick(32'h0000007F);
    set_in(1, 2'b01, 1, 2'b10, 0, 2'd3, 32'h80F17F02, 32'h11, 32'h44, 5'd6); tick(32'hFFFF80F1);
    set_in(1, 2'b01, 1, 2'b11, 1, 2'd2, 32'h80F17F02, 32'h11, 32'h44, 5'd6); tick(32'h80F17F02);
    set_in(1, 2'b01, 1, 2'b01, 0, 2'd0, 32'h80F17F02, 32'h11, 32'h44, 5'd6); tick(32'h00000002);

    // Zero register, no-write and invalid slots.
    set_in(1, 2'b00, 1, 2'b00, 0, 2'd0, 32'h0, 32'h33, 32'h0, 5'd0); tick(32'h33);
    set_in(1, 2'b00, 0, 2'b00, 0, 2'd0, 32'h0, 32'h34, 32'h0, 5'd9); tick(32'h34);
    set_in(0, 2'b00, 1, 2'b00, 0, 2'd0, 32'h0, 32'h35, 32'h0, 5'd9); tick(32'h35);

    // Stall holds A while inputs change, then flush+stall invalidates.
    set_in(1, 2'b00, 1, 2'b00, 0, 2'd0, 32'h0, 32'hA5A5, 32'h0, 5'd7); tick(32'hA5A5);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 2'b10, 1, 2'b00, 0, 2'd0, 32'h0, 32'hFFFF + i, 32'h1234 + i, 5'd3 + 5'(i));
      tick(32'h0);
    end
    flush = 1; tick(32'h0);
    stall = 0; flush = 0;
    set_in(0, 2'b00, 0, 2'b00, 0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0); tick(32'h0);
    set_in(1, 2'b00, 1, 2'b00, 0, 2'd0, 32'h0, 32'h66, 32'h0, 5'd2); tick(32'h66);
    flush = 1;
    set_in(1, 2'b00, 1, 2'b00, 0, 2'd0, 32'h0, 32'h77, 32'h0, 5'd4); tick(32'h0);
    flush = 0;
    set_in(1, 2'b10, 1, 2'b00, 0, 2'd0, 32'h0, 32'h0, 32'h88, 5'd8); tick(32'h88);
    stall = 1; tick(32'h0);
    rst = 1; tick(32'h0);
    rst = 0; stall = 0;

    // Counter: 17 retirements with invalid and flushed slots mixed in.
    for (int i = 0; i < 17; i++) begin
      set_in(1, 2'b00, 1, 2'b00, 0, 2'd0, 32'h0, 32'(i + 1), 32'h0, 5'(i % 31 + 1));
      tick(32'(i + 1));
      if (i % 4 == 3) begin
        set_in(0, 2'b00, 1, 2'b00, 0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd1); tick(32'h0);
        flush = 1;
        set_in(1, 2'b00, 1, 2'b00, 0, 2'd0, 32'h0, 32'h99, 32'h0, 5'd1); tick(32'h0);
        flush = 0;
      end
    end
    set_in(0, 2'b00, 0, 2'b00, 0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0); tick(32'h0);
    chk("c4_wrap_17", {28'd0, c_retired_cnt}, 32'd1);
    chk("cnt_17", {16'd0, retired_cnt}, 32'd17);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
